// File: rtl/bucket_head_table.sv
// rtl/bucket_head_table.sv - bucket index to chain head pointer lookup stage with clear engine (optional write log: HEAD_TABLE_WR_LOG_EN)
module bucket_head_table #(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 32,
    parameter int CMD_WIDTH      = 2,
    parameter int BUCKET_WIDTH   = 8,
    parameter int HEAD_PTR_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [KEY_WIDTH-1:0]      in_key,
    input  logic [VALUE_WIDTH-1:0]    in_value,
    input  logic [CMD_WIDTH-1:0]      in_cmd,
    input  logic [BUCKET_WIDTH-1:0]   in_bucket,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [KEY_WIDTH-1:0]      out_key,
    output logic [VALUE_WIDTH-1:0]    out_value,
    output logic [CMD_WIDTH-1:0]      out_cmd,
    output logic [BUCKET_WIDTH-1:0]   out_bucket,
    output logic [HEAD_PTR_WIDTH-1:0] out_head_ptr,
    output logic                      out_head_ptr_val,
    input  logic [BUCKET_WIDTH-1:0]   wr_addr,
    input  logic [HEAD_PTR_WIDTH-1:0] wr_ptr,
    input  logic                      wr_ptr_val,
    input  logic                      wr_en,
    input  logic                      clear_ram_run_i,
    output logic                      clear_ram_done_o
);

    localparam int DEPTH = 1 << BUCKET_WIDTH;
    localparam int WORD  = HEAD_PTR_WIDTH + 1;

    logic [WORD-1:0]         mem [DEPTH];
    logic [WORD-1:0]         rd_q;
    logic                    valid_q;
    logic [KEY_WIDTH-1:0]    key_q;
    logic [VALUE_WIDTH-1:0]  value_q;
    logic [CMD_WIDTH-1:0]    cmd_q;
    logic [BUCKET_WIDTH-1:0] bucket_q;
    logic                    clr_flag_q, clr_flag_d;
    logic [BUCKET_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [BUCKET_WIDTH-1:0] rd_addr;
    logic                    b_we;
    logic [BUCKET_WIDTH-1:0] b_addr;
    logic [WORD-1:0]         b_data;

    assign in_ready         = out_ready;
    assign out_valid        = valid_q;
    assign out_key          = key_q;
    assign out_value        = value_q;
    assign out_cmd          = cmd_q;
    assign out_bucket       = bucket_q;
    assign out_head_ptr     = rd_q[HEAD_PTR_WIDTH-1:0];
    assign out_head_ptr_val = rd_q[HEAD_PTR_WIDTH];
    assign clear_ram_done_o = clr_flag_q && (&clr_addr_q);

    // While stalled, keep re-reading the held bucket so the head data tracks out_bucket
    assign rd_addr = out_ready ? in_bucket : bucket_q;

    // Port B source: clear engine owns the port while clearing, external writes are dropped
    always_comb begin
        b_we   = wr_en;
        b_addr = wr_addr;
        b_data = {wr_ptr_val, wr_ptr};
        if (clr_flag_q) begin
            b_we   = 1'b1;
            b_addr = clr_addr_q;
            b_data = '0;
        end
    end

    // Clear engine next state: run (re)starts at address 0, done drops the flag
    always_comb begin
        clr_flag_d = clr_flag_q;
        clr_addr_d = clr_addr_q;
        if (clear_ram_run_i) begin
            clr_flag_d = 1'b1;
            clr_addr_d = '0;
        end else if (clr_flag_q) begin
            clr_addr_d = clr_addr_q + BUCKET_WIDTH'(1);
            if (clear_ram_done_o) begin
                clr_flag_d = 1'b0;
            end
        end
    end

    // Clear engine state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clr_flag_q <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            clr_flag_q <= clr_flag_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Forwarding register: loads only when downstream is ready
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            key_q    <= '0;
            value_q  <= '0;
            cmd_q    <= '0;
            bucket_q <= '0;
        end else if (out_ready) begin
            valid_q  <= in_valid;
            key_q    <= in_key;
            value_q  <= in_value;
            cmd_q    <= in_cmd;
            bucket_q <= in_bucket;
        end
    end

    // Port A read register; a same-address write in this cycle yields the old word
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

    // Port B write; RAM contents survive reset
    always_ff @(posedge clk_i) begin
        if (b_we) begin
            mem[b_addr] <= b_data;
        end
    end

`ifdef HEAD_TABLE_WR_LOG_EN
    // Simulation-only trace of every port B write, clear writes included
    always @(posedge clk_i) begin
        if (b_we) begin
            $display("%0t head_table wr addr=%0h ptr=%0h ptr_val=%0b",
                     $time, b_addr, b_data[HEAD_PTR_WIDTH-1:0], b_data[HEAD_PTR_WIDTH]);
        end
    end
`else
`endif

endmodule

// File: tb/tb_bucket_head_table.sv
// tb/tb_bucket_head_table.sv - directed self-checking bench for bucket_head_table
module tb_bucket_head_table;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_key;
    logic [31:0] in_value;
    logic [1:0]  in_cmd;
    logic [7:0]  in_bucket;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_key;
    logic [31:0] out_value;
    logic [1:0]  out_cmd;
    logic [7:0]  out_bucket;
    logic [7:0]  out_head_ptr;
    logic        out_head_ptr_val;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_ptr;
    logic        wr_ptr_val;
    logic        wr_en;
    logic        clear_ram_run_i;
    logic        clear_ram_done_o;

    int n_checks = 0;
    int n_errors = 0;

    bucket_head_table dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_value(in_value),
        .in_cmd(in_cmd), .in_bucket(in_bucket),
        .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key), .out_value(out_value),
        .out_cmd(out_cmd), .out_bucket(out_bucket),
        .out_head_ptr(out_head_ptr), .out_head_ptr_val(out_head_ptr_val),
        .wr_addr(wr_addr), .wr_ptr(wr_ptr), .wr_ptr_val(wr_ptr_val), .wr_en(wr_en),
        .clear_ram_run_i(clear_ram_run_i), .clear_ram_done_o(clear_ram_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic head_write(input logic [7:0] a, input logic [7:0] p, input logic v);
        wr_en = 1'b1; wr_addr = a; wr_ptr = p; wr_ptr_val = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic lookup(input logic [7:0] b, input logic [31:0] k);
        in_valid = 1'b1; in_bucket = b; in_key = k;
        tick();
        in_valid = 1'b0;
    endtask

    // Returns the cycle index (run cycle = 0) at which done is seen, bounded at 600
    task automatic run_clear_wait(output int n);
        clear_ram_run_i = 1'b1;
        tick();
        clear_ram_run_i = 1'b0;
        n = 1;
        while (!clear_ram_done_o && n < 600) begin
            tick();
            n++;
        end
    endtask

    int          n;
    logic [8:0]  acc;
    int          seen_done;

    initial begin
        rst_i = 1'b1; in_valid = 0; in_key = 0; in_value = 0; in_cmd = 0; in_bucket = 0;
        out_ready = 1'b1; wr_addr = 0; wr_ptr = 0; wr_ptr_val = 0; wr_en = 0; clear_ram_run_i = 0;
        tick(); tick();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_key", out_key, 0);
        check_eq("rst_out_bucket", out_bucket, 0);
        check_eq("rst_done", clear_ram_done_o, 0);
        rst_i = 1'b0;
        tick();

        // 1. full clear, then every bucket must read zero
        run_clear_wait(n);
        check_eq("clear1_latency", n, 256);
        tick();
        check_eq("clear1_done_drops", clear_ram_done_o, 0);
        acc = '0;
        for (int i = 0; i < 256; i++) begin
            lookup(8'(i), 32'h0);
            acc = acc | {out_head_ptr_val, out_head_ptr};
        end
        check_eq("clear1_all_zero", acc, 0);

        // 2. write then lookup
        head_write(8'h05, 8'h3A, 1'b1);
        in_value = 32'hCAFE_0001; in_cmd = 2'd2;
        lookup(8'h05, 32'h1234);
        check_eq("lk_valid", out_valid, 1);
        check_eq("lk_key", out_key, 32'h1234);
        check_eq("lk_value", out_value, 32'hCAFE_0001);
        check_eq("lk_cmd", out_cmd, 2);
        check_eq("lk_bucket", out_bucket, 8'h05);
        check_eq("lk_ptr", out_head_ptr, 8'h3A);
        check_eq("lk_ptr_val", out_head_ptr_val, 1);

        // 3. stall with different inputs presented
        in_valid = 1'b0; in_bucket = 8'h09; in_key = 32'hFFFF; out_ready = 1'b0;
        #1;
        check_eq("stall_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_key", out_key, 32'h1234);
            check_eq("stall_bucket", out_bucket, 8'h05);
            check_eq("stall_ptr", {out_head_ptr_val, out_head_ptr}, {1'b1, 8'h3A});
        end
        out_ready = 1'b1;
        tick();
        check_eq("unstall_valid", out_valid, 0);

        // 4. read-during-write returns old data, next read returns new
        head_write(8'h07, 8'h11, 1'b1);
        wr_en = 1'b1; wr_addr = 8'h07; wr_ptr = 8'h22; wr_ptr_val = 1'b1;
        in_valid = 1'b1; in_bucket = 8'h07; in_key = 32'h7;
        tick();
        wr_en = 1'b0;
        check_eq("rdw_old", {out_head_ptr_val, out_head_ptr}, {1'b1, 8'h11});
        tick();
        in_valid = 1'b0;
        check_eq("rdw_new", {out_head_ptr_val, out_head_ptr}, {1'b1, 8'h22});

        // 5. external write mid-clear is lost
        clear_ram_run_i = 1'b1;
        tick();
        clear_ram_run_i = 1'b0;
        repeat (50) tick();
        head_write(8'h10, 8'h55, 1'b1);
        n = 52;
        while (!clear_ram_done_o && n < 600) begin
            tick();
            n++;
        end
        check_eq("clear2_latency", n, 256);
        tick();
        lookup(8'h10, 32'h10);
        check_eq("midclear_wr_lost", {out_head_ptr_val, out_head_ptr}, 9'h0);
        lookup(8'h05, 32'h5);
        check_eq("clear2_b05", {out_head_ptr_val, out_head_ptr}, 9'h0);

        // 6. reset aborts a clear without done; RAM partly cleared
        head_write(8'hF0, 8'h77, 1'b1);
        clear_ram_run_i = 1'b1;
        tick();
        clear_ram_run_i = 1'b0;
        repeat (20) tick();
        rst_i = 1'b1;
        #1;
        check_eq("abort_rst_valid", out_valid, 0);
        tick();
        rst_i = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (clear_ram_done_o) seen_done++;
        end
        check_eq("abort_no_done", seen_done, 0);
        lookup(8'hF0, 32'hF0);
        check_eq("abort_partial", {out_head_ptr_val, out_head_ptr}, {1'b1, 8'h77});
        run_clear_wait(n);
        check_eq("clear3_latency", n, 256);
        tick();
        lookup(8'hF0, 32'hF0);
        check_eq("clear3_bF0", {out_head_ptr_val, out_head_ptr}, 9'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
